viterbi_ber_checker: RTL and testbench
======================================

// Module: viterbi_ber_checker
// PURPOSE
//  Bit-error-rate checker downstream of VITERBIDECODER. Buffers source bits X (encoder input side),
//  discards the decoder's warm-up outputs, then compares each decoded bit against the buffered
//  reference and counts mismatches. Synthesizable; replaces manual waveform checks in error-injection runs.
// PARAMETERS
//  DEPTH   32  reference FIFO depth in bits (power of 2)
//  CNT_W   16  width of BitLen, BitCnt, ErrCnt, FirstErrIdx
//  LAT_W   8   width of Latency
// PORTS
//  CLOCK        in   1       system clock, all logic on posedge
//  Reset        in   1       asynchronous, active-low reset
//  Start        in   1       1-cycle pulse: clear state, begin a run
//  Latency      in   LAT_W   number of leading DecValid strobes to discard, sampled on Start
//  BitLen       in   CNT_W   bits to compare per run, sampled on Start; 0 = run until next Start
//  RefValid     in   1       RefBit strobe (one per source bit period)
//  RefBit       in   1       source bit X
//  DecValid     in   1       DecBit strobe (one per decoded bit)
//  DecBit       in   1       DecodeOut
//  Busy         out  1       high in SKIP or CHECK
//  Done         out  1       level, high in DONE state
//  BitCnt       out  CNT_W   bits compared this run
//  ErrCnt       out  CNT_W   mismatches this run, saturating at all-ones
//  ErrPulse     out  1       1-cycle pulse on each mismatch
//  ErrFlag      out  1       sticky: any mismatch this run
//  Ovf          out  1       sticky: RefValid dropped because FIFO full
//  Udf          out  1       sticky: DecValid in CHECK with FIFO empty
//  FirstErrIdx  out  CNT_W   BitCnt value of first mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, Reset=0): state IDLE; FIFO empty; all outputs 0.
//  States: IDLE -Start-> SKIP (Latency!=0) or CHECK (Latency==0).
//   SKIP: each DecValid decrements skip counter, DecBit ignored, FIFO not popped; at count 0 -> CHECK.
//   CHECK: each DecValid with FIFO non-empty pops 1 ref bit, compares, BitCnt+=1; mismatch -> ErrCnt+=1
//     (saturating), ErrPulse=1 next cycle, ErrFlag=1. When BitCnt reaches BitLen (BitLen!=0) -> DONE.
//   DONE: counters frozen, Done=1; further DecValid ignored; RefValid ignored. Start -> new run.
//  Registered outputs: BitCnt/ErrCnt/flags update 1 cycle after the DecValid edge that caused them.
//  FIFO: RefValid pushes in SKIP and CHECK only (ignored in IDLE/DONE). Push when full -> bit dropped, Ovf=1.
//   Push+pop same cycle: allowed at any occupancy incl. full (occupancy unchanged, no Ovf).
//   Pop when empty in CHECK -> no compare, BitCnt unchanged, Udf=1.
//  Start in any state (incl. mid-run): synchronous restart: FIFO flushed, BitCnt/ErrCnt/flags/
//   FirstErrIdx cleared, Latency/BitLen resampled; a RefValid in the Start cycle is pushed as first bit.
//   DecValid in the Start cycle is ignored.
//  Start and final compare in the same cycle: Start wins, no DONE.
//  Reset mid-run: immediate return to IDLE, all state cleared.
// CONFIGURATION
//  VD_BER_FIRSTERR_EN defined: FirstErrIdx captures BitCnt (pre-increment, 0-based) of the first mismatch
//   of the run; holds until Start/Reset. Undefined: FirstErrIdx tied to 0, no capture register.
// TESTING
//  Latency=0, BitLen=18, Ref=Dec=18'b1_0101_1010_1_0101_1010 -> Done, BitCnt=18, ErrCnt=0, ErrFlag=0.
//  Latency=5, 5 junk DecBits, then bits 3 and 10 inverted of 18 -> ErrCnt=2, two ErrPulses,
//   FirstErrIdx=3 (macro on) / 0 (macro off).
//  DEPTH=32, 33 RefValid with no DecValid in CHECK -> Ovf=1, 32 bits buffered; 32 pops compare clean.
//  DecValid with no RefValid after Start, Latency=0 -> Udf=1, BitCnt=0.
//  Start pulsed mid-run at BitCnt=7, ErrCnt=2 -> next cycle BitCnt=0, ErrCnt=0, ErrFlag=0, state CHECK/SKIP.
//  CNT_W=4, BitLen=0, 20 mismatched bits -> ErrCnt saturates at 15, BitCnt wraps; Reset low -> all 0.

Source files
------------

// File: rtl/viterbi_ber_checker_if.sv
// viterbi_ber_checker_if
//   Run-control, reference/decoded bit strobes and result bus of the
//   Viterbi BER checker.
//   master : drives Start/Latency/BitLen/RefValid/RefBit/DecValid/DecBit,
//            observes the results.
//   slave  : the checker; consumes the strobes and drives Busy, Done,
//            BitCnt, ErrCnt, ErrPulse, ErrFlag, Ovf, Udf, FirstErrIdx.
interface viterbi_ber_checker_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT_W = 8
);
  logic             Start;
  logic [LAT_W-1:0] Latency;
  logic [CNT_W-1:0] BitLen;
  logic             RefValid;
  logic             RefBit;
  logic             DecValid;
  logic             DecBit;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] BitCnt;
  logic [CNT_W-1:0] ErrCnt;
  logic             ErrPulse;
  logic             ErrFlag;
  logic             Ovf;
  logic             Udf;
  logic [CNT_W-1:0] FirstErrIdx;

  modport master (
    output Start, Latency, BitLen, RefValid, RefBit, DecValid, DecBit,
    input  Busy, Done, BitCnt, ErrCnt, ErrPulse, ErrFlag, Ovf, Udf, FirstErrIdx
  );

  modport slave (
    input  Start, Latency, BitLen, RefValid, RefBit, DecValid, DecBit,
    output Busy, Done, BitCnt, ErrCnt, ErrPulse, ErrFlag, Ovf, Udf, FirstErrIdx
  );
endinterface

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
//   Bit-error-rate checker placed after the Viterbi decoder. Buffers source
//   bits in a DEPTH-bit FIFO, discards the first Latency decoded strobes,
//   then compares every decoded bit with the buffered reference and counts
//   mismatches until BitLen bits were compared (BitLen=0: until next Start).
// Ports
//   CLOCK : system clock, posedge
//   Reset : asynchronous, active-low reset
//   bus   : viterbi_ber_checker_if.slave
//           in : Start, Latency, BitLen, RefValid, RefBit, DecValid, DecBit
//           out: Busy, Done, BitCnt, ErrCnt, ErrPulse, ErrFlag, Ovf, Udf,
//                FirstErrIdx
// Build option
//   VD_BER_FIRSTERR_EN : when defined, FirstErrIdx holds the 0-based index of
//   the first mismatch of the run; otherwise it is tied to zero.
module viterbi_ber_checker #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT_W = 8
) (
  input logic                  CLOCK,
  input logic                  Reset,
  viterbi_ber_checker_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0] mem_q;
  logic [LAT_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic             errpulse_q, errpulse_d;
  logic             errflag_q, errflag_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
`ifdef VD_BER_FIRSTERR_EN
  logic [CNT_W-1:0] first_q, first_d;
`endif

  logic [AW:0]      occ;
  logic             full, empty, active, pop, push, mismatch, wr_en;
  logic [AW-1:0]    wr_addr;

  always_comb begin
    occ      = wptr_q - rptr_q;
    full     = (occ == (AW+1)'(DEPTH));
    empty    = (occ == '0);
    active   = (state_q == SKIP) || (state_q == CHECK);
    pop      = (state_q == CHECK) && bus.DecValid && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    push     = active && bus.RefValid && (!full || pop);
    mismatch = pop && (mem_q[rptr_q[AW-1:0]] != bus.DecBit);

    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    skip_d     = skip_q;
    len_d      = len_q;
    bitcnt_d   = bitcnt_q;
    errcnt_d   = errcnt_q;
    errpulse_d = 1'b0;
    errflag_d  = errflag_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    wr_en      = 1'b0;
    wr_addr    = wptr_q[AW-1:0];
`ifdef VD_BER_FIRSTERR_EN
    first_d    = first_q;
`endif

    if (bus.Start) begin
      state_d   = (bus.Latency != '0) ? SKIP : CHECK;
      skip_d    = bus.Latency;
      len_d     = bus.BitLen;
      rptr_d    = '0;
      wptr_d    = {{AW{1'b0}}, bus.RefValid};
      wr_en     = bus.RefValid;
      wr_addr   = '0;
      bitcnt_d  = '0;
      errcnt_d  = '0;
      errflag_d = 1'b0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
`ifdef VD_BER_FIRSTERR_EN
      first_d   = '0;
`endif
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      if (active && bus.RefValid && full && !pop)
        ovf_d = 1'b1;
      if ((state_q == SKIP) && bus.DecValid) begin
        skip_d = skip_q - 1'b1;
        if (skip_q == LAT_W'(1))
          state_d = CHECK;
      end
      if ((state_q == CHECK) && bus.DecValid && empty)
        udf_d = 1'b1;
      if (pop) begin
        rptr_d   = rptr_q + 1'b1;
        bitcnt_d = bitcnt_q + 1'b1;
        if (mismatch) begin
          errpulse_d = 1'b1;
          errflag_d  = 1'b1;
          if (errcnt_q != '1)
            errcnt_d = errcnt_q + 1'b1;
`ifdef VD_BER_FIRSTERR_EN
          if (!errflag_q)
            first_d = bitcnt_q;
`endif
        end
        if ((len_q != '0) && (bitcnt_d == len_q))
          state_d = DONE;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      skip_q     <= '0;
      len_q      <= '0;
      bitcnt_q   <= '0;
      errcnt_q   <= '0;
      errpulse_q <= 1'b0;
      errflag_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
`ifdef VD_BER_FIRSTERR_EN
      first_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      skip_q     <= skip_d;
      len_q      <= len_d;
      bitcnt_q   <= bitcnt_d;
      errcnt_q   <= errcnt_d;
      errpulse_q <= errpulse_d;
      errflag_q  <= errflag_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
`ifdef VD_BER_FIRSTERR_EN
      first_q    <= first_d;
`endif
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge CLOCK) begin
    if (wr_en)
      mem_q[wr_addr] <= bus.RefBit;
  end

  assign bus.Busy     = active;
  assign bus.Done     = (state_q == DONE);
  assign bus.BitCnt   = bitcnt_q;
  assign bus.ErrCnt   = errcnt_q;
  assign bus.ErrPulse = errpulse_q;
  assign bus.ErrFlag  = errflag_q;
  assign bus.Ovf      = ovf_q;
  assign bus.Udf      = udf_q;
`ifdef VD_BER_FIRSTERR_EN
  assign bus.FirstErrIdx = first_q;
`else
  assign bus.FirstErrIdx = '0;
`endif
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker
//   Directed bench for viterbi_ber_checker: a default instance (DEPTH=32,
//   CNT_W=16) and a CNT_W=4 instance for counter saturation/wrap.
module tb_viterbi_ber_checker;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  viterbi_ber_checker_if #(.CNT_W(16), .LAT_W(8)) a();
  viterbi_ber_checker_if #(.CNT_W(4),  .LAT_W(8)) b();

  viterbi_ber_checker #(.DEPTH(32), .CNT_W(16), .LAT_W(8)) u_dut (
    .CLOCK (clk),
    .Reset (rst_n),
    .bus   (a)
  );

  viterbi_ber_checker #(.DEPTH(32), .CNT_W(4), .LAT_W(8)) u_dut4 (
    .CLOCK (clk),
    .Reset (rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock on the default instance; strobes are cleared afterwards.
  task automatic a_cycle(input logic st, input logic rv, input logic rb,
                         input logic dv, input logic db);
    a.Start = st; a.RefValid = rv; a.RefBit = rb; a.DecValid = dv; a.DecBit = db;
    @(posedge clk); #1;
    a.Start = 1'b0; a.RefValid = 1'b0; a.DecValid = 1'b0;
  endtask

  task automatic b_cycle(input logic st, input logic rv, input logic rb,
                         input logic dv, input logic db);
    b.Start = st; b.RefValid = rv; b.RefBit = rb; b.DecValid = dv; b.DecBit = db;
    @(posedge clk); #1;
    b.Start = 1'b0; b.RefValid = 1'b0; b.DecValid = 1'b0;
  endtask

  initial begin
    logic [31:0] pat;
    logic [63:0] p2;
    int          pulses;
    logic        db;

    n_checks = 0;
    n_fail   = 0;
    pat = 32'b0_1_0101_1010_1_0101_1010;
    p2  = 64'hDEAD_BEEF_1234_5678;
    a.Start = 1'b0; a.Latency = '0; a.BitLen = '0;
    a.RefValid = 1'b0; a.RefBit = 1'b0; a.DecValid = 1'b0; a.DecBit = 1'b0;
    b.Start = 1'b0; b.Latency = '0; b.BitLen = '0;
    b.RefValid = 1'b0; b.RefBit = 1'b0; b.DecValid = 1'b0; b.DecBit = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(a.Busy), 0);
    chk("rst_done",   32'(a.Done), 0);
    chk("rst_bitcnt", 32'(a.BitCnt), 0);
    chk("rst_errcnt", 32'(a.ErrCnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: clean 18-bit run, Latency=0
    a.Latency = 8'd0; a.BitLen = 16'd18;
    a_cycle(1'b1, 1'b1, pat[0], 1'b0, 1'b0);
    chk("t1_busy", 32'(a.Busy), 1);
    for (int i = 0; i < 18; i++) begin
      a_cycle(1'b0, (i < 17), pat[i+1], 1'b1, pat[i]);
      if (i == 0) chk("t1_first_bitcnt", 32'(a.BitCnt), 1);
    end
    chk("t1_done",    32'(a.Done), 1);
    chk("t1_busy_end",32'(a.Busy), 0);
    chk("t1_bitcnt",  32'(a.BitCnt), 18);
    chk("t1_errcnt",  32'(a.ErrCnt), 0);
    chk("t1_errflag", 32'(a.ErrFlag), 0);
    chk("t1_ovf_udf", 32'({a.Ovf, a.Udf}), 0);
    a_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t1_done_frozen", 32'(a.BitCnt), 18);

    // 2: Latency=5, bits 3 and 10 inverted
    a.Latency = 8'd5; a.BitLen = 16'd18;
    a_cycle(1'b1, 1'b1, pat[0], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) a_cycle(1'b0, 1'b0, 1'b0, 1'b1, i[0]);
    chk("t2_skip_bitcnt", 32'(a.BitCnt), 0);
    chk("t2_skip_busy",   32'(a.Busy), 1);
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      db = pat[i] ^ ((i == 3) || (i == 10));
      a_cycle(1'b0, (i < 17), pat[i+1], 1'b1, db);
      if (a.ErrPulse === 1'b1) pulses++;
    end
    chk("t2_pulses",  32'(pulses), 2);
    chk("t2_errcnt",  32'(a.ErrCnt), 2);
    chk("t2_errflag", 32'(a.ErrFlag), 1);
    chk("t2_done",    32'(a.Done), 1);
    chk("t2_bitcnt",  32'(a.BitCnt), 18);
`ifdef VD_BER_FIRSTERR_EN
    chk("t2_firsterr", 32'(a.FirstErrIdx), 3);
`else
    chk("t2_firsterr", 32'(a.FirstErrIdx), 0);
`endif

    // 3: FIFO overflow, then drain 32 clean compares
    a.Latency = 8'd0; a.BitLen = 16'd0;
    a_cycle(1'b1, 1'b1, p2[0], 1'b0, 1'b0);
    for (int k = 1; k < 32; k++) a_cycle(1'b0, 1'b1, p2[k], 1'b0, 1'b0);
    chk("t3_full_no_ovf", 32'(a.Ovf), 0);
    a_cycle(1'b0, 1'b1, p2[32], 1'b0, 1'b0);
    chk("t3_ovf", 32'(a.Ovf), 1);
    for (int k = 0; k < 32; k++) a_cycle(1'b0, 1'b0, 1'b0, 1'b1, p2[k]);
    chk("t3_bitcnt", 32'(a.BitCnt), 32);
    chk("t3_errcnt", 32'(a.ErrCnt), 0);
    chk("t3_udf_before", 32'(a.Udf), 0);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_udf_after", 32'(a.Udf), 1);
    chk("t3_bitcnt_hold", 32'(a.BitCnt), 32);

    // 4: underflow; DecValid in the Start cycle is ignored
    a.Latency = 8'd0; a.BitLen = 16'd0;
    a_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_start_udf", 32'(a.Udf), 0);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_udf",    32'(a.Udf), 1);
    chk("t4_bitcnt", 32'(a.BitCnt), 0);

    // 5: Start mid-run at BitCnt=7, ErrCnt=2
    a.Latency = 8'd0; a.BitLen = 16'd0;
    a_cycle(1'b1, 1'b1, pat[0], 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      db = pat[i] ^ ((i == 1) || (i == 4));
      a_cycle(1'b0, 1'b1, pat[i+1], 1'b1, db);
    end
    chk("t5_pre_bitcnt", 32'(a.BitCnt), 7);
    chk("t5_pre_errcnt", 32'(a.ErrCnt), 2);
    a.Latency = 8'd2;
    a_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_bitcnt",  32'(a.BitCnt), 0);
    chk("t5_errcnt",  32'(a.ErrCnt), 0);
    chk("t5_errflag", 32'(a.ErrFlag), 0);
    chk("t5_busy",    32'(a.Busy), 1);
    chk("t5_firsterr",32'(a.FirstErrIdx), 0);

    // 5b: Start coincides with the final compare: Start wins
    a.Latency = 8'd0; a.BitLen = 16'd3;
    a_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    a_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    a_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5b_bitcnt_pre", 32'(a.BitCnt), 2);
    a_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5b_done",   32'(a.Done), 0);
    chk("t5b_bitcnt", 32'(a.BitCnt), 0);
    chk("t5b_busy",   32'(a.Busy), 1);

    // 6: CNT_W=4 saturation and wrap
    b.Latency = 8'd0; b.BitLen = 4'd0;
    b_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) b_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_errcnt_sat", 32'(b.ErrCnt), 15);
    chk("t6_bitcnt_wrap",32'(b.BitCnt), 4);
    chk("t6_errflag",    32'(b.ErrFlag), 1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_bitcnt",  32'(b.BitCnt), 0);
    chk("rst2_errcnt",  32'(b.ErrCnt), 0);
    chk("rst2_errflag", 32'(b.ErrFlag), 0);
    chk("rst2_busy",    32'({a.Busy, b.Busy}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
